// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encodings, the controller state enum, the default operand
// width and the divide-by-zero LO value.
// Optional build macro used by the unit: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // LO result of a divide by zero: all ones.
  localparam logic [DEF_WIDTH-1:0] DIV0_LO = '1;

  // Signed ops (mult, div) work on magnitudes and fix the sign afterwards.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bus between the execute-stage control and the multiply/divide unit.
// master: pipeline side (drives start/op/operands and mthi/mtlo strobes).
// slave : muldiv_unit (drives busy, done and the HI/LO registers).
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::DEF_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_abs.sv
// Combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
// Ports:
//   i_val  value to process
//   i_neg  1 = output -i_val, 0 = pass i_val through
//   o_val  result
module muldiv_abs #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_val
);
  assign o_val = i_neg ? (~i_val + {{(N-1){1'b0}}, 1'b1}) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over WIDTH CALC cycles,
// followed by one FIX cycle for sign correction and the HI/LO write.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   bus     muldiv_if slave: start/op/a/b, hi_we/lo_we/wdata in;
//           busy, done, hi, lo out (all registered)
// Build macro MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining
// multiplier bits are zero; FIX then realigns the accumulator.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int              CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] L_DIV0_LO = {WIDTH{DIV0_LO[0]}};

  state_e             r_state;
  state_e             w_next;
  logic [1:0]         r_op;
  logic               r_neg_a;
  logic               r_neg_b;
  // multiplicand (multiply) or divisor (divide) magnitude
  logic [WIDTH-1:0]   r_opnd;
  // multiply: {partial product, remaining multiplier}; divide: {remainder, quotient}
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic               w_start;
  logic               w_neg_a_in;
  logic               w_neg_b_in;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_neg_prod;
  logic               w_neg_quo;
  logic               w_neg_rem;
  logic               w_div0;
  logic               w_early;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_start    = (r_state == IDLE) && bus.start;
  assign w_neg_a_in = op_is_signed(bus.op) && bus.a[WIDTH-1];
  assign w_neg_b_in = op_is_signed(bus.op) && bus.b[WIDTH-1];

  muldiv_abs #(.N(WIDTH)) u_abs_a (.i_val(bus.a), .i_neg(w_neg_a_in), .o_val(w_abs_a));
  muldiv_abs #(.N(WIDTH)) u_abs_b (.i_val(bus.b), .i_neg(w_neg_b_in), .o_val(w_abs_b));

  // Multiply step: conditionally add the multiplicand into the top half,
  // then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: shift the next dividend bit into the remainder and keep
  // the difference only when it does not go negative.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
  assign w_step      = r_op[1] ? w_div_next : w_mul_next;

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    w_shamt;

  // Shadow of the unconsumed multiplier bits, used only for the exit test.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mplier <= '0;
    end else if (w_start) begin
      r_mplier <= w_abs_b;
    end else if (r_state == CALC) begin
      r_mplier <= r_mplier >> 1;
    end else begin
      r_mplier <= r_mplier;
    end
  end

  // After k steps the partial product sits WIDTH-k bits too high.
  assign w_early = !r_op[1] && (r_mplier[WIDTH-1:1] == '0);
  assign w_shamt = CW'(WIDTH) - r_cnt;
  assign w_prod  = r_acc >> w_shamt;
`else
  assign w_early = 1'b0;
  assign w_prod  = r_acc;
`endif

  // Sign flags are already zero for unsigned ops.
  assign w_neg_prod = !r_op[1] && (r_neg_a ^ r_neg_b);
  assign w_neg_quo  = r_op[1] && (r_neg_a ^ r_neg_b);
  assign w_neg_rem  = r_op[1] && r_neg_a;
  assign w_div0     = r_op[1] && (r_opnd == '0);

  muldiv_abs #(.N(2*WIDTH)) u_fix_prod (.i_val(w_prod), .i_neg(w_neg_prod), .o_val(w_prod_fix));
  muldiv_abs #(.N(WIDTH)) u_fix_quo (.i_val(r_acc[WIDTH-1:0]), .i_neg(w_neg_quo), .o_val(w_quo_fix));
  muldiv_abs #(.N(WIDTH)) u_fix_rem (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(w_neg_rem), .o_val(w_rem_fix));

  // A zero divisor leaves remainder = |a|, which the remainder sign fix
  // turns back into a; only LO needs forcing.
  assign w_res_hi = r_op[1] ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo = r_op[1] ? (w_div0 ? L_DIV0_LO : w_quo_fix) : w_prod_fix[WIDTH-1:0];

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Controller next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = CALC;
        end else begin
          w_next = IDLE;
        end
      end
      CALC: begin
        if ((r_cnt == LAST_STEP) || w_early) begin
          w_next = FIX;
        end else begin
          w_next = CALC;
        end
      end
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath, HI/LO registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op    <= 2'b00;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
          if (w_start) begin
            r_op    <= bus.op;
            r_neg_a <= w_neg_a_in;
            r_neg_b <= w_neg_b_in;
            r_cnt   <= '0;
            if (bus.op[1]) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
            end
          end
        end
        CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit owning the HI/LO registers.
- Takes the long-latency MIPS ops that the single-cycle ALU does not handle: mult, multu, div, divu, mthi, mtlo.
- Sits beside the ALU in the execute stage.
- The pipeline control stalls on busy and reads hi/lo for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; hi and lo are WIDTH each; iteration count = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request new operation; sampled when busy=0
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- hi_we  in  1  mthi write strobe
- lo_we  in  1  mtlo write strobe
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; hi/lo valid this cycle
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: state=IDLE; busy=0; done=0; hi=0; lo=0; all internal registers 0.
- Reset mid-operation aborts the op with no hi/lo update.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 latches op, |a|, |b| and the sign flags.
  - Signed ops take magnitudes; unsigned ops take raw values.
  - Clear counter; go to CALC; busy=1 from the next cycle.
- CALC:
  - One radix-2 step per cycle for WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing remainder and quotient.
  - Counter reaching WIDTH-1 moves to FIX.
- FIX, one cycle:
  - Apply sign correction.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient negative if signs differ; remainder takes the dividend's sign.
  - Write hi = product[63:32] or remainder; lo = product[31:0] or quotient.
  - Pulse done=1 for this cycle; next state IDLE with busy=0.
- Latency: start in cycle N gives done and the new hi/lo in cycle N+WIDTH+2 (34 for WIDTH=32).
- start while busy=1: ignored; no queuing.
- start and hi_we/lo_we in the same IDLE cycle: the write applies; the op then overwrites at completion.
- hi_we/lo_we while busy=1: dropped.
- Divide by zero: no trap; hi=a (dividend, unmodified); lo=all ones; same latency.
- Signed divide of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0; no flag.
- hi/lo hold their value at all other times.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - Multiply leaves CALC as soon as the remaining multiplier bits are all zero, after at least one iteration.
  - The accumulator is shifted into its final alignment in FIX.
  - Latency is variable: between 3 and WIDTH+2 cycles.
  - Divide latency is unchanged.
- When undefined: fixed WIDTH+2 latency for all ops.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum {IDLE, CALC, FIX};
  - WIDTH default;
  - DIV0_LO constant (all ones).
- One natural sub-module: muldiv_abs, a combinational conditional two's-complement negate/absolute helper.
  - Instantiated for operand preparation and for result sign fix.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 34 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- mult a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. The same operands via multu -> hi=0x00000004, lo=0xFFFFFFF1.
- div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=0 -> hi=0x00000007, lo=0xFFFFFFFF.
- div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0. In the same run, mthi 0x1234 while busy -> dropped; hi shows the op result.
- Second start held high while busy -> ignored, with exactly one done pulse. rst_n=0 at cycle 10 of a mult -> busy=0, hi=lo=0 next cycle, no done.
- MULDIV_EARLY_OUT_EN defined, multu a=0x10 b=0x3 -> done at cycle 4 with lo=0x30. Undefined -> done at cycle 34, same result.
